// File: rtl/tdm_pkg.sv
// Shared types and constants for the four-slot TDM receive path.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package tdm_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam int SLOT_W    = 2;
   localparam int NUM_SLOTS = 4;

   localparam logic [SLOT_W-1:0] SLOT_A = 2'd0;
   localparam logic [SLOT_W-1:0] SLOT_B = 2'd1;
   localparam logic [SLOT_W-1:0] SLOT_C = 2'd2;
   localparam logic [SLOT_W-1:0] SLOT_D = 2'd3;

endpackage

// File: rtl/tdm_demux4_if.sv
// Bundle of the shared TDM line, its marker, and the de-multiplexed frame outputs.
// Latency: n/a (wiring only).
// Backpressure: none; en is a sample enable, not a handshake.
interface tdm_demux4_if #(
   parameter int WIDTH = 1
);
   logic             en;
   logic             frame_sync;
   logic [WIDTH-1:0] bus_in;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] d;
   logic             s0;
   logic             s1;
   logic             frame_valid;
   logic             locked;
   logic             sync_err;

   // Line driver / frame consumer side
   modport master (
      output en, frame_sync, bus_in,
      input  a, b, c, d, s0, s1, frame_valid, locked, sync_err
   );

   // De-multiplexer side
   modport slave (
      input  en, frame_sync, bus_in,
      output a, b, c, d, s0, s1, frame_valid, locked, sync_err
   );
endinterface

// File: rtl/tdm_slot_ctr.sv
// Two-bit slot counter: increments on each enabled sample, wraps 3->0, with load-to-1 and clear.
// Latency: new slot value visible one clock after the enabled edge.
// Backpressure: holds its value whenever i_en is low.
module tdm_slot_ctr
   import tdm_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_load1,
   input  logic              i_clr,
   output logic [SLOT_W-1:0] o_slot
);

   logic [SLOT_W-1:0] r_slot;

   // Clear wins over load; otherwise advance and wrap at the last slot
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_slot <= SLOT_A;
      end else if (i_en) begin
         if (i_clr)
            r_slot <= SLOT_A;
         else if (i_load1)
            r_slot <= SLOT_B;
         else if (r_slot == SLOT_W'(NUM_SLOTS - 1))
            r_slot <= SLOT_A;
         else
            r_slot <= r_slot + SLOT_W'(1);
      end
   end

   assign o_slot = r_slot;

endmodule

// File: rtl/tdm_demux4.sv
// Aligns to the slot-0 marker on a shared TDM line and presents each complete 4-slot frame in parallel.
// Latency: slot d appears one clock after it is sampled; a..d update together with a frame_valid pulse.
// Backpressure: none; en low freezes everything, stretching the frame without error.
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int WIDTH      = 1,
   parameter int MISS_LIMIT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   tdm_demux4_if.slave bus
);

   localparam logic [2:0] MISS_LIM = 3'(MISS_LIMIT);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [2:0]        r_miss;
   logic [2:0]        w_miss_nxt;
   logic [2:0]        w_miss_inc;
   logic [SLOT_W-1:0] w_slot;
   logic              w_ctr_clr;
   logic              w_ctr_load;
   logic              w_sh_a_we;
   logic              w_sh_b_we;
   logic              w_sh_c_we;
   logic              w_out_we;
   logic              w_sync_err;
   logic [WIDTH-1:0]  r_sh_a;
   logic [WIDTH-1:0]  r_sh_b;
   logic [WIDTH-1:0]  r_sh_c;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [WIDTH-1:0]  r_c;
   logic [WIDTH-1:0]  r_d;
   logic              r_frame_valid;
   logic              r_sync_err;

   assign w_miss_inc = r_miss + 3'd1;

   tdm_slot_ctr u_slot_ctr (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_en    (bus.en),
      .i_load1 (w_ctr_load),
      .i_clr   (w_ctr_clr),
      .o_slot  (w_slot)
   );

   // Next-state, miss tracking and capture strobes; nothing moves while en is low
   always_comb begin
      w_state_nxt = r_state;
      w_miss_nxt  = r_miss;
      w_ctr_clr   = 1'b0;
      w_ctr_load  = 1'b0;
      w_sh_a_we   = 1'b0;
      w_sh_b_we   = 1'b0;
      w_sh_c_we   = 1'b0;
      w_out_we    = 1'b0;
      w_sync_err  = 1'b0;
      if (bus.en) begin
         case (r_state)
            HUNT: begin
               if (bus.frame_sync) begin
                  w_state_nxt = LOCKED;
                  w_miss_nxt  = 3'd0;
                  w_sh_a_we   = 1'b1;
                  w_ctr_load  = 1'b1;
               end else begin
                  w_ctr_clr   = 1'b1;
               end
            end
            LOCKED: begin
               if (w_slot == SLOT_A) begin
                  if (bus.frame_sync) begin
                     w_miss_nxt = 3'd0;
                     w_sh_a_we  = 1'b1;
                     w_ctr_load = 1'b1;
                  end else if (w_miss_inc == MISS_LIM) begin
                     // Too many consecutive missing markers: give up and hunt again
                     w_state_nxt = HUNT;
                     w_miss_nxt  = 3'd0;
                     w_ctr_clr   = 1'b1;
                  end else begin
                     // Flywheel through a missing marker
                     w_miss_nxt = w_miss_inc;
                     w_sh_a_we  = 1'b1;
                     w_ctr_load = 1'b1;
                  end
               end else if (bus.frame_sync) begin
                  // Marker in the wrong slot: drop the partial frame and realign to it
                  w_sync_err = 1'b1;
                  w_miss_nxt = 3'd0;
                  w_sh_a_we  = 1'b1;
                  w_ctr_load = 1'b1;
               end else begin
                  case (w_slot)
                     SLOT_B:  w_sh_b_we = 1'b1;
                     SLOT_C:  w_sh_c_we = 1'b1;
                     default: w_out_we  = 1'b1;
                  endcase
               end
            end
            default: w_state_nxt = HUNT;
         endcase
      end
   end

   // FSM state and consecutive-miss count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= HUNT;
         r_miss  <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_miss  <= w_miss_nxt;
      end
   end

   // Shadow capture of slots 0..2 and atomic update of the visible frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_a <= '0;
         r_sh_b <= '0;
         r_sh_c <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_c    <= '0;
         r_d    <= '0;
      end else begin
         if (w_sh_a_we) r_sh_a <= bus.bus_in;
         if (w_sh_b_we) r_sh_b <= bus.bus_in;
         if (w_sh_c_we) r_sh_c <= bus.bus_in;
         if (w_out_we) begin
            r_a <= r_sh_a;
            r_b <= r_sh_b;
            r_c <= r_sh_c;
            r_d <= bus.bus_in;
         end
      end
   end

   // Single-cycle status pulses, aligned with the edge that caused them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_valid <= 1'b0;
         r_sync_err    <= 1'b0;
      end else begin
         r_frame_valid <= w_out_we;
         r_sync_err    <= w_sync_err;
      end
   end

   assign bus.a           = r_a;
   assign bus.b           = r_b;
   assign bus.c           = r_c;
   assign bus.d           = r_d;
   assign bus.s1          = w_slot[1];
   assign bus.s0          = w_slot[0];
   assign bus.frame_valid = r_frame_valid;
   assign bus.sync_err    = r_sync_err;
   assign bus.locked      = (r_state == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Randomized and directed stimulus for tdm_demux4 with a queue-based scoreboard.
// Latency: expected pulses are tagged with the clock count at which they must appear.
// Backpressure: en gaps are part of the stimulus.
module tb_tdm_demux4;

   localparam int W  = 4;
   localparam int ML = 2;

   typedef struct {
      bit           err;
      int           cyc;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] c;
      logic [W-1:0] d;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   tdm_demux4_if #(.WIDTH(W)) bus ();

   tdm_demux4 #(.WIDTH(W), .MISS_LIMIT(ML)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_vec = 0;
   int n_err = 0;
   exp_t q[$];

   // Reference model: frame-level view of the receiver
   bit           m_locked;
   int           m_slot;
   int           m_miss;
   logic [W-1:0] m_frame [4];
   logic [4*W-1:0] prev;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input bit err);
      exp_t e;
      e.err = err;
      e.cyc = cyc + 1;
      e.a = m_frame[0];
      e.b = m_frame[1];
      e.c = m_frame[2];
      e.d = m_frame[3];
      q.push_back(e);
   endtask

   task automatic model(input bit e, input bit fs, input logic [W-1:0] d);
      if (!e) return;
      if (!m_locked) begin
         if (fs) begin
            m_frame[0] = d;
            m_slot = 1;
            m_locked = 1;
            m_miss = 0;
         end
      end else if (m_slot == 0) begin
         m_miss = fs ? 0 : m_miss + 1;
         if (!fs && m_miss == ML) begin
            m_locked = 0;
            m_slot = 0;
            m_miss = 0;
         end else begin
            m_frame[0] = d;
            m_slot = 1;
         end
      end else if (fs) begin
         push(1'b1);
         m_frame[0] = d;
         m_slot = 1;
         m_miss = 0;
      end else begin
         m_frame[m_slot] = d;
         if (m_slot == 3) begin
            push(1'b0);
            m_slot = 0;
         end else begin
            m_slot++;
         end
      end
   endtask

   task automatic step(input bit e, input bit fs, input logic [W-1:0] d);
      @(negedge clk);
      bus.en = e;
      bus.frame_sync = fs;
      bus.bus_in = d;
      model(e, fs, d);
      @(posedge clk);
      #1;
      chk("locked", 32'(bus.locked), 32'(m_locked));
      chk("slot", 32'({bus.s1, bus.s0}), 32'(m_slot));
   endtask

   task automatic frame(input bit mk, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] d);
      step(1'b1, mk, a);
      step(1'b1, 1'b0, b);
      step(1'b1, 1'b0, c);
      step(1'b1, 1'b0, d);
   endtask

   // Monitor: pops the scoreboard whenever the DUT pulses, and polices output stability
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev = {bus.a, bus.b, bus.c, bus.d};
      end else begin
         if (bus.frame_valid && bus.sync_err) chk("pulse_exclusive", 32'd1, 32'd0);
         while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            chk(e.err ? "missed_sync_err" : "missed_frame_valid", 32'd0, 32'd1);
         end
         if (bus.frame_valid || bus.sync_err) begin
            if (q.size() == 0) begin
               chk("spurious_pulse", 32'({bus.frame_valid, bus.sync_err}), 32'd0);
            end else begin
               e = q.pop_front();
               chk("pulse_kind", 32'(bus.sync_err), 32'(e.err));
               chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
               if (!e.err)
                  chk("frame_abcd", 32'({bus.a, bus.b, bus.c, bus.d}), 32'({e.a, e.b, e.c, e.d}));
            end
         end
         if (!bus.frame_valid)
            chk("hold_abcd", 32'({bus.a, bus.b, bus.c, bus.d}), 32'(prev));
         prev = {bus.a, bus.b, bus.c, bus.d};
      end
   end

   initial begin
      bit fs;
      bus.en = 1'b0;
      bus.frame_sync = 1'b0;
      bus.bus_in = '0;
      m_locked = 0;
      m_slot = 0;
      m_miss = 0;
      for (int i = 0; i < 4; i++) m_frame[i] = '0;

      #12;
      chk("reset_abcd", 32'({bus.a, bus.b, bus.c, bus.d}), 32'd0);
      chk("reset_locked", 32'(bus.locked), 32'd0);
      chk("reset_slot", 32'({bus.s1, bus.s0}), 32'd0);
      chk("reset_pulses", 32'({bus.frame_valid, bus.sync_err}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Lock acquisition and three clean frames
      step(1'b1, 1'b0, 4'h9);
      repeat (3) frame(1'b1, 4'h1, 4'h0, 4'h1, 4'h1);
      frame(1'b1, 4'hA, 4'h5, 4'hC, 4'h3);

      // en gap between slots b and c
      step(1'b1, 1'b1, 4'h2);
      step(1'b1, 1'b0, 4'h4);
      for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom), W'($urandom));
      step(1'b1, 1'b0, 4'h6);
      step(1'b1, 1'b0, 4'h8);

      // Marker at slot 2: realign, then complete the realigned and a fresh frame
      step(1'b1, 1'b1, 4'h5);
      step(1'b1, 1'b0, 4'h6);
      step(1'b1, 1'b1, 4'h7);
      step(1'b1, 1'b0, 4'h8);
      step(1'b1, 1'b0, 4'h9);
      step(1'b1, 1'b0, 4'hE);
      frame(1'b1, 4'hF, 4'h1, 4'h2, 4'h3);

      // Two consecutive missing markers drop lock, next marker relocks
      frame(1'b0, 4'h4, 4'h5, 4'h6, 4'h7);
      frame(1'b0, 4'h8, 4'h9, 4'hA, 4'hB);
      frame(1'b1, 4'hC, 4'hD, 4'hE, 4'h0);

      // Asynchronous reset with the counter at slot 2
      step(1'b1, 1'b1, 4'h3);
      step(1'b1, 1'b0, 4'h3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_abcd", 32'({bus.a, bus.b, bus.c, bus.d}), 32'd0);
      chk("arst_locked", 32'(bus.locked), 32'd0);
      chk("arst_slot", 32'({bus.s1, bus.s0}), 32'd0);
      chk("arst_pulses", 32'({bus.frame_valid, bus.sync_err}), 32'd0);
      m_locked = 0;
      m_slot = 0;
      m_miss = 0;
      bus.en = 1'b0;
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      frame(1'b0, 4'h1, 4'h2, 4'h3, 4'h4);
      frame(1'b1, 4'h5, 4'h6, 4'h7, 4'h8);

      // Randomized traffic: mostly well-formed, with gaps, misses and stray markers
      for (int i = 0; i < 400; i++) begin
         if (m_slot == 0) fs = ($urandom % 8) != 0;
         else             fs = ($urandom % 16) == 0;
         step(($urandom % 5) != 0, fs, W'($urandom));
      end

      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      chk("pending_expectations", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Receive-side counterpart of the team's 4:1 tri-state bus multiplexer. One shared line carries four channels a, b, c, d time-division multiplexed, with a frame marker on slot 0. This block aligns to that marker, tracks the slot number on s1/s0 (same encoding as the mux selects), and de-multiplexes the four slots into registered parallel outputs. It sits at the far end of the shared bus and presents one coherent frame at a time to downstream logic.

## Interface
- WIDTH, 1, width of the bus and of each channel
- MISS_LIMIT, 2, consecutive missing frame markers tolerated before dropping lock (range 1..7)

- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  sample enable; when low, all state holds
- bus_in  input  WIDTH  shared TDM data line
- frame_sync  input  1  high while slot 0 (channel a) is on bus_in
- a, b, c, d  output  WIDTH  last complete frame, registered
- s0, s1  output  1  slot expected at the next sample (s1 is MSB); 0=a, 1=b, 2=c, 3=d
- frame_valid  output  1  one-cycle pulse when a, b, c, d update
- locked  output  1  high in state LOCKED
- sync_err  output  1  one-cycle pulse on a frame marker at a non-zero slot

## Operation
- States:
  - HUNT: reset state, locked=0.
  - LOCKED: locked=1.
- Slot counter: 2 bits, wraps 3→0. Shadow registers sh_a, sh_b, sh_c hold slots 0 to 2 of the frame in progress.
- When en=0, no state, counter, shadow, or output changes. frame_valid and sync_err are 0.
- HUNT, en=1:
  - frame_sync=0: stay in HUNT, counter stays 0.
  - frame_sync=1: sh_a←bus_in, counter←1, go to LOCKED, miss count←0.
- LOCKED, en=1, counter=0:
  - If frame_sync=1, miss count←0.
  - If frame_sync=0, miss count←miss count+1. If the new count equals MISS_LIMIT: go to HUNT, counter←0, no capture.
  - Otherwise (no drop to HUNT), sh_a←bus_in and counter←1.
- LOCKED, en=1, counter=1 or 2:
  - frame_sync=0: capture into sh_b or sh_c, counter+1.
  - frame_sync=1: sync_err pulses. Realign: sh_a←bus_in, counter←1, partial frame discarded, miss count←0.
- LOCKED, en=1, counter=3:
  - frame_sync=0: {a,b,c,d}←{sh_a,sh_b,sh_c,bus_in} in one edge, frame_valid pulses, counter←0.
  - frame_sync=1: sync_err pulses, realign as above, no frame_valid, outputs keep the old frame.
- a..d change only together, only on a frame_valid edge. A torn frame is never visible.
- {s1,s0} equals the counter at all times.

## Timing
- Reset (asynchronous on rst_n low, released synchronously by design):
  - a, b, c, d = 0; s1=s0=0; frame_valid=0; locked=0; sync_err=0.
  - State HUNT; counter, miss count, and shadows = 0.
- Latency: channel d is visible on output d one clock after its slot is sampled. Channel a is visible four sampled slots after being sampled, in steady state.
- Lock acquisition: locked rises on the edge that samples the first frame_sync=1. The first frame_valid comes three enabled samples later.
- Reset mid-frame discards the shadows. The next frame needs a new marker.
- frame_valid and sync_err are mutually exclusive in any cycle.
- Throughput: one frame per 4 enabled cycles. en gaps stretch the frame without error.

## Structure
- Package tdm_pkg:
  - state enum {HUNT, LOCKED}
  - SLOT_W=2, NUM_SLOTS=4
  - slot constants SLOT_A..SLOT_D
- Sub-module tdm_slot_ctr: 2-bit counter with en, load-to-1, and clear-to-0. It drives s1/s0.
- Top: FSM, miss counter, shadows, output registers.

## Test plan
- Reset, then 3 frames with marker on slot 0 and data a=1,b=0,c=1,d=1 (WIDTH=1):
  - locked rises on the first marker.
  - frame_valid pulses every 4th cycle.
  - Outputs read 1,0,1,1.
  - s1/s0 cycles 1,2,3,0.
- en deasserted for 5 cycles between slots b and c:
  - No state change during the gap.
  - The frame completes correctly after en returns.
  - Exactly one frame_valid.
- Marker at slot 2 while LOCKED:
  - sync_err pulses once.
  - No frame_valid for the broken frame.
  - Outputs hold their previous values.
  - The next full frame captures correctly.
- Marker omitted on 2 consecutive frames (MISS_LIMIT=2):
  - First miss: frame still captured.
  - Second miss: locked falls, state HUNT.
  - The next marker relocks.
- rst_n pulsed low asynchronously mid-frame (counter=2):
  - All outputs return to 0 immediately, without waiting for a clock edge.
  - No frame_valid until a new marker plus 3 slots.
